// File: rtl/cross_mul_sched_pkg.sv
// Shared types and constants for the cross-product multiplier scheduler.
// Operand packs hold six DW-bit fields; the offsets below are field indices, not bit positions.
package geo_pkg;

    localparam int DW   = 10;
    localparam int CP_W = 2 * DW + 2;
    localparam int NF   = 6;

    localparam int OX  = 0;
    localparam int OY  = 1;
    localparam int P1X = 2;
    localparam int P1Y = 3;
    localparam int P2X = 4;
    localparam int P2Y = 5;

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        DONE
    } state_t;

    // Unsigned coordinates are widened by one bit so the difference is a proper signed value.
    function automatic logic signed [DW:0] diff_u(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/cross_mul_sched_if.sv
// Requester-side bus of the cross-product scheduler: level requests, operand packs, grant/done and result.
interface cross_mul_sched_if #(
    parameter int N_REQ = 2,
    parameter int DW    = geo_pkg::DW
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*6*DW-1:0]   op;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic signed [2*DW+1:0]  result;
    logic                    is_neg;
    logic                    is_zero;
    logic                    busy;

    modport master (
        output req, op,
        input  gnt, done, result, is_neg, is_zero, busy
    );

    modport slave (
        input  req, op,
        output gnt, done, result, is_neg, is_zero, busy
    );

endinterface

// File: rtl/cross_mul_sched_rr_arbiter.sv
// Combinational round-robin pick: the requester after last_ptr has highest priority.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    last_ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);

    logic          found;
    logic [PW-1:0] cand;

    // Walk the ring starting one past the last winner; the first active request wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(last_ptr) + k) % N_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/cross_mul_sched.sv
// Time-shares one signed (DW+1)x(DW+1) multiplier between requesters computing (p1-o) x (p2-o).
// Sequence: capture differences, first product, second product and subtract, one-cycle done.
module cross_mul_sched
    import geo_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    cross_mul_sched_if.slave bus
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OPW = NF * DW;

    state_t                 state;
    logic [N_REQ-1:0]       gnt_q;
    logic [N_REQ-1:0]       arb_gnt;
    logic [PW-1:0]          last_ptr;
    logic [PW-1:0]          win_q;
    logic [PW-1:0]          arb_idx;
    logic [OPW-1:0]         sel_op;
    logic signed [DW:0]     d1x;
    logic signed [DW:0]     d1y;
    logic signed [DW:0]     d2x;
    logic signed [DW:0]     d2y;
    logic signed [DW:0]     mul_a;
    logic signed [DW:0]     mul_b;
    logic signed [CP_W-1:0] prod_a;
    logic signed [CP_W-1:0] mul_out;
    logic signed [CP_W-1:0] cp_next;
    logic signed [CP_W-1:0] result_q;
    logic                   is_neg_q;
    logic                   is_zero_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req      (bus.req),
        .last_ptr (last_ptr),
        .en       (state == IDLE),
        .gnt      (arb_gnt),
        .idx      (arb_idx)
    );

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_op = bus.op[i*OPW +: OPW];
            end
        end
    end

    // The single multiplier: MUL1 forms d1x*d2y, every other cycle presents d2x*d1y for MUL2.
    always_comb begin
        mul_a = d2x;
        mul_b = d1y;
        if (state == MUL1) begin
            mul_a = d1x;
            mul_b = d2y;
        end
        mul_out = CP_W'(mul_a) * CP_W'(mul_b);
        cp_next = prod_a - mul_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_q     <= '0;
            win_q     <= '0;
            last_ptr  <= PW'(N_REQ - 1);
            d1x       <= '0;
            d1y       <= '0;
            d2x       <= '0;
            d2y       <= '0;
            prod_a    <= '0;
            result_q  <= '0;
            is_neg_q  <= 1'b0;
            is_zero_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q <= arb_gnt;
                        win_q <= arb_idx;
                        d1x   <= diff_u(sel_op[P1X*DW +: DW], sel_op[OX*DW +: DW]);
                        d1y   <= diff_u(sel_op[P1Y*DW +: DW], sel_op[OY*DW +: DW]);
                        d2x   <= diff_u(sel_op[P2X*DW +: DW], sel_op[OX*DW +: DW]);
                        d2y   <= diff_u(sel_op[P2Y*DW +: DW], sel_op[OY*DW +: DW]);
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    prod_a <= mul_out;
                    state  <= MUL2;
                end
                MUL2: begin
                    result_q  <= cp_next;
                    is_neg_q  <= cp_next[CP_W-1];
                    is_zero_q <= (cp_next == '0);
                    state     <= DONE;
                end
                DONE: begin
                    last_ptr <= win_q;
                    gnt_q    <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = (state == DONE) ? gnt_q : '0;
    assign bus.result  = result_q;
    assign bus.is_neg  = is_neg_q;
    assign bus.is_zero = is_zero_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_cross_mul_sched.sv
// Randomized self-checking bench for cross_mul_sched against a plain-arithmetic reference model.
module tb_cross_mul_sched;
    import geo_pkg::*;

    localparam int N    = 2;
    localparam int CMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   last_srv;
    int   fld [N][6];

    cross_mul_sched_if #(.N_REQ(N), .DW(DW)) bus ();

    cross_mul_sched #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_cross(input int r);
        return (fld[r][2] - fld[r][0]) * (fld[r][5] - fld[r][1])
             - (fld[r][4] - fld[r][0]) * (fld[r][3] - fld[r][1]);
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] one_hot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_ops();
        for (int r = 0; r < N; r++)
            for (int f = 0; f < 6; f++)
                bus.op[(r*6+f)*DW +: DW] = DW'(fld[r][f]);
    endtask

    task automatic rand_fields(input int r);
        for (int f = 0; f < 6; f++) fld[r][f] = int'($urandom_range(0, CMAX));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        last_srv = N - 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.result !== '0 || bus.is_neg !== 1'b0 ||
            bus.is_zero !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_values: gnt=%b done=%b result=%0d neg=%b zero=%b busy=%b, want 0 0 0 0 1 0",
                     bus.gnt, bus.done, bus.result, bus.is_neg, bus.is_zero, bus.busy);
        end
        reset    = 1'b0;
        last_srv = N - 1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
            fails++;
            $display("[TB] FAIL idle_no_req: busy=%b gnt=%b, want 0 00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_single();
        int vec [5][6] = '{'{0, 0, 10, 0, 0, 10}, '{0, 0, 0, 10, 10, 0}, '{5, 5, 6, 6, 9, 9},
                           '{1023, 1023, 0, 1023, 1023, 0}, '{0, 1023, 1023, 0, 0, 0}};
        int want [5] = '{100, -100, 0, 1046529, -1046529};
        int got;
        for (int v = 0; v < 5; v++) begin
            for (int f = 0; f < 6; f++) fld[0][f] = vec[v][f];
            drive_ops();
            bus.req = 2'b01;
            @(negedge clk);
            tests++;
            if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
                fails++;
                $display("[TB] FAIL single_gnt[%0d]: gnt=%b busy=%b, want 01 1", v, bus.gnt, bus.busy);
            end
            @(negedge clk);
            tests++;
            if (bus.done !== '0) begin
                fails++;
                $display("[TB] FAIL single_early_done[%0d]: done=%b, want 00", v, bus.done);
            end
            @(negedge clk);
            got = bus.result;
            tests++;
            if (bus.done !== 2'b01 || got !== want[v] || got !== ref_cross(0) ||
                bus.is_neg !== (want[v] < 0) || bus.is_zero !== (want[v] == 0)) begin
                fails++;
                $display("[TB] FAIL single_result[%0d]: done=%b result=%0d neg=%b zero=%b, want done=01 result=%0d",
                         v, bus.done, got, bus.is_neg, bus.is_zero, want[v]);
            end
            bus.req  = '0;
            last_srv = 0;
            @(negedge clk);
            got = bus.result;
            tests++;
            if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.done !== '0 || got !== want[v]) begin
                fails++;
                $display("[TB] FAIL single_hold[%0d]: busy=%b gnt=%b done=%b result=%0d, want 0 00 00 %0d",
                         v, bus.busy, bus.gnt, bus.done, got, want[v]);
            end
        end
    endtask

    task automatic test_contention();
        int w;
        int got;
        pulse_reset();
        rand_fields(0);
        rand_fields(1);
        drive_ops();
        bus.req = 2'b11;
        for (int n = 0; n < 2; n++) begin
            w = pick(last_srv, bus.req);
            if (n == 1) @(negedge clk);
            @(negedge clk);
            tests++;
            if (bus.gnt !== one_hot(w)) begin
                fails++;
                $display("[TB] FAIL contention_gnt[%0d]: gnt=%b, want %b", n, bus.gnt, one_hot(w));
            end
            @(negedge clk);
            @(negedge clk);
            got = bus.result;
            tests++;
            if (bus.done !== one_hot(w) || got !== ref_cross(w)) begin
                fails++;
                $display("[TB] FAIL contention_done[%0d]: done=%b result=%0d, want %b %0d",
                         n, bus.done, got, one_hot(w), ref_cross(w));
            end
            bus.req[w] = 1'b0;
            last_srv   = w;
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int events = 0;
        int cyc    = 0;
        int w;
        int got;
        rand_fields(0);
        rand_fields(1);
        drive_ops();
        bus.req = 2'b11;
        while (events < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done !== '0) begin
                w   = pick(last_srv, 2'b11);
                got = bus.result;
                tests++;
                if (bus.done !== one_hot(w) || got !== ref_cross(w)) begin
                    fails++;
                    $display("[TB] FAIL alternate[%0d]: done=%b result=%0d, want %b %0d",
                             events, bus.done, got, one_hot(w), ref_cross(w));
                end
                last_srv = w;
                events++;
                if (events == 4) bus.req = '0;
            end
        end
        if (events < 4) begin
            tests++;
            fails++;
            $display("[TB] FAIL alternate_timeout: saw %0d done pulses, want 4", events);
            bus.req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_stability();
        int expv;
        int pulses = 0;
        int got    = 0;
        rand_fields(0);
        drive_ops();
        expv    = ref_cross(0);
        bus.req = 2'b01;
        @(negedge clk);
        rand_fields(0);
        drive_ops();
        bus.req = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done !== '0) begin
                pulses++;
                got = bus.result;
                tests++;
                if (bus.done !== 2'b01) begin
                    fails++;
                    $display("[TB] FAIL stability_done_bit: done=%b, want 01", bus.done);
                end
            end
        end
        last_srv = 0;
        tests++;
        if (pulses != 1 || got !== expv) begin
            fails++;
            $display("[TB] FAIL stability: pulses=%0d result=%0d, want 1 %0d", pulses, got, expv);
        end
    endtask

    task automatic test_reset_mid_op();
        int w;
        int got;
        for (int pass = 0; pass < 2; pass++) begin
            rand_fields(0);
            rand_fields(1);
            drive_ops();
            bus.req = 2'b01;
            @(negedge clk);
            @(negedge clk);
            reset   = 1'b1;
            bus.req = '0;
            @(negedge clk);
            reset    = 1'b0;
            last_srv = N - 1;
            tests++;
            if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.done !== '0) begin
                fails++;
                $display("[TB] FAIL abort_state[%0d]: busy=%b gnt=%b done=%b, want 0 00 00",
                         pass, bus.busy, bus.gnt, bus.done);
            end
            if (pass == 0) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    tests++;
                    if (bus.done !== '0) begin
                        fails++;
                        $display("[TB] FAIL abort_no_done: done=%b, want 00", bus.done);
                    end
                end
                bus.req = 2'b10;
                @(negedge clk);
                tests++;
                if (bus.gnt !== 2'b10) begin
                    fails++;
                    $display("[TB] FAIL abort_req1_gnt: gnt=%b, want 10", bus.gnt);
                end
                @(negedge clk);
                @(negedge clk);
                got = bus.result;
                tests++;
                if (bus.done !== 2'b10 || got !== ref_cross(1)) begin
                    fails++;
                    $display("[TB] FAIL abort_req1_done: done=%b result=%0d, want 10 %0d",
                             bus.done, got, ref_cross(1));
                end
                bus.req  = '0;
                last_srv = 1;
                @(negedge clk);
            end
            bus.req = 2'b11;
            w       = pick(last_srv, 2'b11);
            @(negedge clk);
            tests++;
            if (bus.gnt !== one_hot(w)) begin
                fails++;
                $display("[TB] FAIL abort_tie_gnt[%0d]: gnt=%b, want %b", pass, bus.gnt, one_hot(w));
            end
            @(negedge clk);
            @(negedge clk);
            got = bus.result;
            tests++;
            if (bus.done !== one_hot(w) || got !== ref_cross(w)) begin
                fails++;
                $display("[TB] FAIL abort_tie_done[%0d]: done=%b result=%0d, want %b %0d",
                         pass, bus.done, got, one_hot(w), ref_cross(w));
            end
            bus.req  = '0;
            last_srv = w;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int w;
        int n;
        int got;
        for (int it = 0; it < 24; it++) begin
            for (int r = 0; r < N; r++) rand_fields(r);
            if (it % 6 == 0) begin
                for (int f = 0; f < 6; f++) fld[0][f] = (f % 2 == 0) ? CMAX : 0;
            end
            drive_ops();
            mask    = N'($urandom_range(1, (1 << N) - 1));
            w       = pick(last_srv, mask);
            bus.req = mask;
            n       = 0;
            @(negedge clk);
            tests++;
            if (bus.gnt !== one_hot(w)) begin
                fails++;
                $display("[TB] FAIL random_gnt[%0d]: gnt=%b, want %b", it, bus.gnt, one_hot(w));
            end
            while (bus.done === '0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            got = bus.result;
            tests++;
            if (n != 2 || bus.done !== one_hot(w) || got !== ref_cross(w) ||
                bus.is_neg !== (ref_cross(w) < 0) || bus.is_zero !== (ref_cross(w) == 0)) begin
                fails++;
                $display("[TB] FAIL random_done[%0d]: wait=%0d done=%b result=%0d neg=%b zero=%b, want 2 %b %0d",
                         it, n, bus.done, got, bus.is_neg, bus.is_zero, one_hot(w), ref_cross(w));
            end
            bus.req  = '0;
            last_srv = w;
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.req  = '0;
        bus.op   = '0;
        last_srv = N - 1;
        test_reset();
        test_single();
        test_contention();
        test_alternate();
        test_stability();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
